// File: rtl/cook_timer_pkg.sv
// cook_timer shared definitions
// state encoding and BCD digit constants
package cook_timer_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] BCD_MAX      = 4'd9;
    localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SET  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/bcd_down_digit.sv
// one BCD digit of the countdown
// clear > load > decrement; wraps to WRAP with borrow at 0
module bcd_down_digit
    import cook_timer_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] WRAP = BCD_MAX
) (
    input  logic               i_clk,
    input  logic               i_resetn,
    input  logic               i_clr,
    input  logic               i_load,
    input  logic [DIGIT_W-1:0] i_load_val,
    input  logic               i_dec,
    output logic [DIGIT_W-1:0] o_q,
    output logic               o_borrow_out
);

    logic [DIGIT_W-1:0] r_q;

    assign o_q          = r_q;
    assign o_borrow_out = i_dec && (r_q == '0);

    // digit register: clear, load or decrement with wrap
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_load_val;
        end else if (i_dec) begin
            r_q <= (r_q == '0) ? WRAP : r_q - 4'd1;
        end
    end

endmodule

// File: rtl/cook_timer.sv
// MM:SS BCD cook timer for the microwave controller
// keypad shift-in entry, 1 Hz countdown while enabled
module cook_timer
    import cook_timer_pkg::*;
#(
    parameter int CLK_DIV = 50000000,
    parameter int DIV_W   = 26
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               enable,
    input  logic               clearn,
    input  logic               key_valid,
    input  logic [DIGIT_W-1:0] key_digit,
    output logic [DIGIT_W-1:0] sec_ones,
    output logic [DIGIT_W-1:0] sec_tens,
    output logic [DIGIT_W-1:0] min_ones,
    output logic [DIGIT_W-1:0] min_tens,
    output logic               timer_done,
    output logic               zero
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    state_t           r_state;
    logic [DIV_W-1:0] r_div;
    logic             r_done;

    logic w_clr;
    logic w_key_ok;
    logic w_key_zero;
    logic w_zero;
    logic w_run;
    logic w_tick;
    logic w_last;
    logic w_b_so;
    logic w_b_st;
    logic w_b_mo;
    logic w_b_mt;

    assign w_clr    = !clearn;
    assign w_key_ok = key_valid && (key_digit <= BCD_MAX) && !enable;

    assign w_zero = (sec_ones == '0) && (sec_tens == '0) &&
                    (min_ones == '0) && (min_tens == '0);

    assign w_key_zero = (key_digit == '0) && (sec_ones == '0) &&
                        (sec_tens == '0) && (min_ones == '0);

    // SET counts as runnable so a resumed partial second is not stretched
    assign w_run  = enable && !w_zero &&
                    ((r_state == SET) || (r_state == RUN));
    assign w_tick = w_run && (r_div == DIV_LAST);
    assign w_last = w_tick && (sec_ones == 4'd1) && (sec_tens == '0) &&
                    (min_ones == '0) && (min_tens == '0);

    assign timer_done = r_done;
    assign zero       = w_zero;

    bcd_down_digit #(.WRAP(BCD_MAX)) u_sec_ones (
        .i_clk        (clk),
        .i_resetn     (resetn),
        .i_clr        (w_clr),
        .i_load       (w_key_ok),
        .i_load_val   (key_digit),
        .i_dec        (w_tick),
        .o_q          (sec_ones),
        .o_borrow_out (w_b_so)
    );

    bcd_down_digit #(.WRAP(SEC_TENS_MAX)) u_sec_tens (
        .i_clk        (clk),
        .i_resetn     (resetn),
        .i_clr        (w_clr),
        .i_load       (w_key_ok),
        .i_load_val   (sec_ones),
        .i_dec        (w_b_so),
        .o_q          (sec_tens),
        .o_borrow_out (w_b_st)
    );

    bcd_down_digit #(.WRAP(BCD_MAX)) u_min_ones (
        .i_clk        (clk),
        .i_resetn     (resetn),
        .i_clr        (w_clr),
        .i_load       (w_key_ok),
        .i_load_val   (sec_tens),
        .i_dec        (w_b_st),
        .o_q          (min_ones),
        .o_borrow_out (w_b_mo)
    );

    bcd_down_digit #(.WRAP(BCD_MAX)) u_min_tens (
        .i_clk        (clk),
        .i_resetn     (resetn),
        .i_clr        (w_clr),
        .i_load       (w_key_ok),
        .i_load_val   (min_ones),
        .i_dec        (w_b_mo),
        .o_q          (min_tens),
        .o_borrow_out (w_b_mt)
    );

    // control FSM: prescaler, done flag and run/pause/expiry state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_div   <= '0;
            r_done  <= 1'b0;
        end else if (w_clr) begin
            r_state <= IDLE;
            r_div   <= '0;
            r_done  <= 1'b0;
        end else if (w_key_ok) begin
            r_div   <= '0;
            r_done  <= 1'b0;
            r_state <= w_key_zero ? IDLE : SET;
        end else if (w_tick) begin
            r_div <= '0;
            if (w_last) begin
                r_done  <= 1'b1;
                r_state <= DONE;
            end else begin
                r_state <= RUN;
            end
        end else if (w_run) begin
            r_div   <= r_div + 1'b1;
            r_state <= RUN;
        end else if ((r_state == RUN) && !enable) begin
            r_state <= SET;
        end else if ((r_state == IDLE) && enable) begin
            r_done  <= 1'b1;
            r_state <= DONE;
        end
    end

    logic w_unused;
    assign w_unused = w_b_mt;

endmodule

// File: tb/tb_cook_timer.sv
// directed bench for cook_timer
// CLK_DIV=4 so one second is four clocks
module tb_cook_timer;

    logic       clk;
    logic       resetn;
    logic       enable;
    logic       clearn;
    logic       key_valid;
    logic [3:0] key_digit;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min_ones;
    logic [3:0] min_tens;
    logic       timer_done;
    logic       zero;

    int total = 0;
    int bad   = 0;

    cook_timer #(.CLK_DIV(4), .DIV_W(3)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .enable     (enable),
        .clearn     (clearn),
        .key_valid  (key_valid),
        .key_digit  (key_digit),
        .sec_ones   (sec_ones),
        .sec_tens   (sec_tens),
        .min_ones   (min_ones),
        .min_tens   (min_tens),
        .timer_done (timer_done),
        .zero       (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] digits();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    task automatic chk(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        step(1);
        key_valid = 1'b0;
    endtask

    task automatic clear();
        clearn = 1'b0;
        step(1);
        clearn = 1'b1;
    endtask

    initial begin
        resetn    = 1'b0;
        enable    = 1'b0;
        clearn    = 1'b1;
        key_valid = 1'b0;
        key_digit = 4'd0;
        #23;
        chk("rst_digits", digits(), 16'h0000);
        chk("rst_done", {15'd0, timer_done}, 16'd0);
        chk("rst_zero", {15'd0, zero}, 16'd1);
        resetn = 1'b1;
        step(1);

        key(4'd1);
        key(4'd3);
        key(4'd0);
        chk("key_130", digits(), 16'h0130);
        chk("key_130_zero", {15'd0, zero}, 16'd0);
        key(4'd11);
        chk("key_bad", digits(), 16'h0130);
        enable = 1'b1;
        key(4'd5);
        enable = 1'b0;
        chk("key_en", digits(), 16'h0130);
        clear();
        chk("clear", digits(), 16'h0000);

        key(4'd0);
        key(4'd5);
        chk("load_05", digits(), 16'h0005);
        enable = 1'b1;
        step(3);
        chk("pre_tick", digits(), 16'h0005);
        step(1);
        chk("cnt_04", digits(), 16'h0004);
        step(4);
        chk("cnt_03", digits(), 16'h0003);
        step(4);
        chk("cnt_02", digits(), 16'h0002);
        step(4);
        chk("cnt_01", digits(), 16'h0001);
        chk("cnt_01_done", {15'd0, timer_done}, 16'd0);
        step(4);
        chk("cnt_00", digits(), 16'h0000);
        chk("exp_done", {15'd0, timer_done}, 16'd1);
        enable = 1'b0;
        step(2);
        chk("done_hold", {15'd0, timer_done}, 16'd1);
        chk("done_dig", digits(), 16'h0000);

        clear();
        key(4'd1);
        key(4'd0);
        key(4'd0);
        key(4'd0);
        chk("load_1000", digits(), 16'h1000);
        chk("key_clr_done", {15'd0, timer_done}, 16'd0);
        enable = 1'b1;
        step(4);
        enable = 1'b0;
        chk("b_0959", digits(), 16'h0959);

        clear();
        key(4'd1);
        key(4'd0);
        key(4'd0);
        enable = 1'b1;
        step(4);
        enable = 1'b0;
        chk("b_0059", digits(), 16'h0059);

        clear();
        key(4'd9);
        key(4'd0);
        chk("load_0090", digits(), 16'h0090);
        enable = 1'b1;
        step(4);
        enable = 1'b0;
        chk("b_0089", digits(), 16'h0089);

        clear();
        key(4'd3);
        enable = 1'b1;
        step(4);
        chk("p_02", digits(), 16'h0002);
        step(2);
        enable = 1'b0;
        step(10);
        chk("p_hold", digits(), 16'h0002);
        enable = 1'b1;
        step(1);
        chk("p_res1", digits(), 16'h0002);
        step(1);
        chk("p_res2", digits(), 16'h0001);
        enable = 1'b0;
        step(1);

        clear();
        key(4'd9);
        enable = 1'b1;
        step(3);
        chk("c_pre", digits(), 16'h0009);
        clearn    = 1'b0;
        key_valid = 1'b1;
        key_digit = 4'd7;
        step(1);
        clearn    = 1'b1;
        key_valid = 1'b0;
        chk("c_dig", digits(), 16'h0000);
        chk("c_done", {15'd0, timer_done}, 16'd0);
        step(1);
        chk("guard", {15'd0, timer_done}, 16'd1);
        enable = 1'b0;

        clear();
        key(4'd5);
        enable = 1'b1;
        step(2);
        resetn = 1'b0;
        #1;
        chk("ar_dig", digits(), 16'h0000);
        chk("ar_done", {15'd0, timer_done}, 16'd0);
        enable = 1'b0;
        #2;
        resetn = 1'b1;
        step(1);
        chk("ar_rel", digits(), 16'h0000);
        chk("ar_rel_done", {15'd0, timer_done}, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
